// File: rtl/disp_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner:
// sequencer state encoding and active-low segment patterns (SEG[0]=a).
package disp_scan_pkg;

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_GAP   = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/disp_scan_hex7seg.sv
// Combinational hex-to-7-segment decoder, active-low outputs, lower-case b and d.
module hex7seg
  import disp_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      4'hF: seg_o = SEG_HEX_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scan.sv
// Multiplexed 7-segment scanner: shadow registers, CE-driven DRIVE/GAP sequencer,
// leading-zero blanking and registered active-low digit/segment outputs.
//   state    | meaning
//   ST_DRIVE | digit [idx] enabled, decoded nibble on SEG
//   ST_GAP   | all digits dark, down-counting CE ticks before next digit
module disp_scan
  import disp_scan_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int GAP_TICKS = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               LOAD,
  input  logic [4*N_DIG-1:0] DAT_I,
  input  logic [N_DIG-1:0]   DP_I,
  input  logic               LZB_I,
  output logic [N_DIG-1:0]   AN,
  output logic [6:0]         SEG,
  output logic               DP
);

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
  localparam logic [3:0] GAP_LOAD = (GAP_TICKS > 0) ? 4'(GAP_TICKS - 1) : 4'd0;

  scan_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
  logic [3:0]         gap_q, gap_d;
  logic [4*N_DIG-1:0] dat_q, dat_d;
  logic [N_DIG-1:0]   dpm_q, dpm_d;
  logic               lzb_q, lzb_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic [3:0] nib_sel;
  logic       dp_sel;
  logic       blank_sel;
  logic       zero_run;
  logic [6:0] seg_hex;

  always_comb begin
    dat_d   = LOAD ? DAT_I : dat_q;
    dpm_d   = LOAD ? DP_I : dpm_q;
    lzb_d   = LOAD ? LZB_I : lzb_q;
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    if (CE) begin
      case (state_q)
        ST_DRIVE: begin
          if (GAP_TICKS > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            idx_d = idx_nxt;
          end
        end
        ST_GAP: begin
          if (gap_q == 4'd0) begin
            state_d = ST_DRIVE;
            idx_d   = idx_nxt;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
        default: state_d = ST_DRIVE;
      endcase
    end
  end

  // Walk from the top digit down so zero_run means "this nibble and all above are zero".
  always_comb begin
    nib_sel   = 4'd0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    zero_run  = 1'b1;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      zero_run = zero_run & (dat_d[4*k +: 4] == 4'd0);
      if (idx_d == IDX_W'(k)) begin
        nib_sel   = dat_d[4*k +: 4];
        dp_sel    = dpm_d[k];
        blank_sel = lzb_d & zero_run & (k != 0);
      end
    end
  end

  hex7seg u_hex7seg (
    .nib_i (nib_sel),
    .seg_o (seg_hex)
  );

  // Outputs are computed from next state so AN/SEG/DP move together one edge after CE.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state_d == ST_DRIVE) begin
      for (int k = 0; k < N_DIG; k++) begin
        if (idx_d == IDX_W'(k)) an_d[k] = 1'b0;
      end
      seg_d = blank_sel ? SEG_BLANK : seg_hex;
      dp_d  = ~dp_sel;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_DRIVE;
      idx_q   <= '0;
      gap_q   <= 4'd0;
      dat_q   <= '0;
      dpm_q   <= '0;
      lzb_q   <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      dat_q   <= dat_d;
      dpm_q   <= dpm_d;
      lzb_q   <= lzb_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan: main instance with one gap tick, second instance
// with no gap and CE tied high.
module tb_disp_scan;

  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19;
  localparam logic [6:0] SA = 7'h08;
  localparam logic [6:0] SF = 7'h0E;
  localparam logic [6:0] SB = 7'h7F;

  logic        CLK;
  logic        RST;
  logic        CE;
  logic        LOAD;
  logic [15:0] DAT_I;
  logic [3:0]  DP_I;
  logic        LZB_I;
  logic [3:0]  AN, AN1;
  logic [6:0]  SEG, SEG1;
  logic        DP, DP1;

  int checks = 0;
  int errors = 0;

  disp_scan #(.N_DIG(4), .GAP_TICKS(1)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .LOAD(LOAD), .DAT_I(DAT_I), .DP_I(DP_I),
    .LZB_I(LZB_I), .AN(AN), .SEG(SEG), .DP(DP)
  );

  disp_scan #(.N_DIG(4), .GAP_TICKS(0)) dut_fast (
    .CLK(CLK), .RST(RST), .CE(1'b1), .LOAD(LOAD), .DAT_I(DAT_I), .DP_I(DP_I),
    .LZB_I(LZB_I), .AN(AN1), .SEG(SEG1), .DP(DP1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    checks++;
    assert (($countones(~AN) <= 1) && ($countones(~AN1) <= 1))
    else begin
      errors++;
      $error("FAIL onehot an=%b an_fast=%b required at most one low bit", AN, AN1);
    end
  end

  task automatic chk(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
    checks++;
    assert ({AN, SEG, DP} === {a, s, d})
    else begin
      errors++;
      $error("FAIL %s got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
             tag, AN, SEG, DP, a, s, d);
    end
  endtask

  task automatic cyc(input logic ce_v, input logic load_v);
    CE   = ce_v;
    LOAD = load_v;
    @(negedge CLK);
    CE   = 1'b0;
    LOAD = 1'b0;
  endtask

  task automatic load(input logic [15:0] dat, input logic [3:0] dp, input logic lzb);
    DAT_I = dat;
    DP_I  = dp;
    LZB_I = lzb;
    cyc(1'b0, 1'b1);
  endtask

  // Starts at DRIVE digit 0, CE every 4 CLK, checks each DRIVE and GAP slot.
  task automatic full_scan(input string tag, input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] one;
    one = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_d%0d", tag, k), ~(one << k), segs[k*7 +: 7], dps[k]);
      repeat (3) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      chk($sformatf("%s_g%0d", tag, k), 4'b1111, SB, 1'b1);
      repeat (3) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_an;
    one   = 4'b0001;
    RST   = 1'b0;
    CE    = 1'b0;
    LOAD  = 1'b0;
    DAT_I = 16'h0;
    DP_I  = 4'h0;
    LZB_I = 1'b0;

    repeat (2) @(negedge CLK);
    chk("reset", 4'b1111, SB, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst", 4'b1110, S0, 1'b1);

    load(16'h1234, 4'b0000, 1'b0);
    full_scan("scan1234", {S1, S2, S3, S4}, 4'b1111);

    load(16'h00A0, 4'b0000, 1'b1);
    full_scan("lzb_on", {SB, SB, SA, S0}, 4'b1111);
    load(16'h00A0, 4'b0000, 1'b0);
    full_scan("lzb_off", {S0, S0, SA, S0}, 4'b1111);

    load(16'h0000, 4'b0100, 1'b1);
    full_scan("zero_dp", {SB, SB, SB, S0}, 4'b1011);

    cyc(1'b1, 1'b0);
    chk("ldce_g0", 4'b1111, SB, 1'b1);
    cyc(1'b1, 1'b0);
    chk("ldce_d1", 4'b1101, SB, 1'b1);
    DAT_I = 16'hFFFF;
    DP_I  = 4'b0000;
    LZB_I = 1'b0;
    cyc(1'b1, 1'b1);
    chk("ldce_g1", 4'b1111, SB, 1'b1);
    cyc(1'b1, 1'b0);
    chk("ldce_d2", 4'b1011, SF, 1'b1);
    cyc(1'b1, 1'b0);
    chk("ldce_g2", 4'b1111, SB, 1'b1);
    cyc(1'b1, 1'b0);
    chk("ldce_d3", 4'b0111, SF, 1'b1);

    repeat (6) cyc(1'b1, 1'b0);
    chk("pre_rst_d2", 4'b1011, SF, 1'b1);
    cyc(1'b1, 1'b0);
    chk("pre_rst_g2", 4'b1111, SB, 1'b1);
    #2 RST = 1'b0;
    #1 chk("rst_gap_async", 4'b1111, SB, 1'b1);
    @(negedge CLK);
    chk("rst_held", 4'b1111, SB, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    chk("restart_d0", 4'b1110, S0, 1'b1);
    cyc(1'b1, 1'b0);
    chk("restart_g0", 4'b1111, SB, 1'b1);
    cyc(1'b1, 1'b0);
    chk("restart_d1_cleared", 4'b1101, S0, 1'b1);

    #2 RST = 1'b0;
    #1 chk("rst_drive_async", 4'b1111, SB, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      exp_an = ~(one << ((k + 1) % 4));
      checks++;
      assert ({AN1, SEG1, DP1} === {exp_an, S0, 1'b1})
      else begin
        errors++;
        $error("FAIL nogap_rot%0d got an=%b seg=%h dp=%b expected an=%b seg=%h dp=1",
               k, AN1, SEG1, DP1, exp_an, S0);
      end
    end
    chk("idle_d0", 4'b1110, S0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
